// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl
//   Multi-cycle load/store unit between the execute stage and data memory.
//   Accepts one RV load/store per transaction, checks legality and alignment,
//   issues a single lane-aligned bus request, waits for the response (with an
//   optional timeout), and returns extended load data or an error code.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_*            request from EXU (valid/ready handshake, accepted in IDLE)
//   mem_req_*       bus request: word-aligned address, byte-lane data and mask
//   mem_rsp_*       bus response: single-cycle valid, full-word data, error flag
//   out_*           result to WBU (valid/ready): load data and 2-bit error code
//                   (00 ok, 01 misaligned/illegal, 10 bus error, 11 timeout)
module lsu_bus_ctrl #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              mem_rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rdata,
    output logic [1:0]        out_err
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t              state_reg, state_next;
    logic                is_load_reg, is_load_next;
    logic [2:0]          funct3_reg, funct3_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [XLEN-1:0]     wdata_reg, wdata_next;
    logic [XLEN-1:0]     rdata_reg, rdata_next;
    logic [1:0]          err_reg, err_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    logic                legal, aligned, in_fault;
    logic [OFF_W-1:0]    off;
    logic [XLEN-1:0]     shifted, load_ext;
    logic [3:0]          lane_lo, lane_hi;

    // Legality of the incoming request, evaluated on the raw inputs so a
    // faulting request goes straight to DONE without touching the bus.
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b1;
        if (in_is_load && !in_is_store) begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                3'b011, 3'b110:                         legal = (XLEN == 64);
                default:                                legal = 1'b0;
            endcase
        end else if (in_is_store && !in_is_load) begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                3'b011:                 legal = (XLEN == 64);
                default:                legal = 1'b0;
            endcase
        end
        case (in_funct3[1:0])
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~in_addr[0];
            2'd2:    aligned = (in_addr[1:0] == 2'b00);
            default: aligned = (in_addr[2:0] == 3'b000);
        endcase
        in_fault = !legal || !aligned;
    end

    // Byte offset within the bus word; drives lane steering both ways.
    assign off     = addr_reg[OFF_W-1:0];
    assign shifted = mem_rsp_rdata >> {off, 3'b000};

    always_comb begin
        case (funct3_reg)
            3'b000:  load_ext = XLEN'($signed(shifted[7:0]));
            3'b001:  load_ext = XLEN'($signed(shifted[15:0]));
            3'b010:  load_ext = XLEN'($signed(shifted[31:0]));
            3'b100:  load_ext = XLEN'(shifted[7:0]);
            3'b101:  load_ext = XLEN'(shifted[15:0]);
            3'b110:  load_ext = XLEN'(shifted[31:0]);
            default: load_ext = shifted;
        endcase
    end

    // Active byte lanes span [off, off + size); reads enable no lanes.
    assign lane_lo = 4'(off);
    assign lane_hi = 4'(off) + (4'd1 << funct3_reg[1:0]);

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign mem_req_wmask[gi] = !is_load_reg && (4'(gi) >= lane_lo) && (4'(gi) < lane_hi);
        end
    endgenerate

    assign mem_req_addr  = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_req_wdata = wdata_reg << {off, 3'b000};
    assign mem_req_valid = (state_reg == S_REQ);
    assign mem_req_wen   = (state_reg == S_REQ) && !is_load_reg;
    assign in_ready      = (state_reg == S_IDLE);
    assign out_valid     = (state_reg == S_DONE);
    assign out_rdata     = rdata_reg;
    assign out_err       = err_reg;

    always_comb begin
        state_next   = state_reg;
        is_load_next = is_load_reg;
        funct3_next  = funct3_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        rdata_next   = rdata_reg;
        err_next     = err_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    is_load_next = in_is_load;
                    funct3_next  = in_funct3;
                    addr_next    = in_addr;
                    wdata_next   = in_wdata;
                    rdata_next   = '0;
                    cnt_next     = '0;
                    if (in_fault) begin
                        err_next   = 2'b01;
                        state_next = S_DONE;
                    end else begin
                        err_next   = 2'b00;
                        state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_next   = '0;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    state_next = S_DONE;
                    if (mem_rsp_err) begin
                        err_next   = 2'b10;
                        rdata_next = '0;
                    end else begin
                        err_next   = 2'b00;
                        rdata_next = is_load_reg ? load_ext : '0;
                    end
                end else if (TO_EN && (cnt_reg == CNT_LAST)) begin
                    state_next = S_DONE;
                    err_next   = 2'b11;
                    rdata_next = '0;
                end else if (TO_EN) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            is_load_reg <= 1'b0;
            funct3_reg  <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            err_reg     <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            is_load_reg <= is_load_next;
            funct3_reg  <= funct3_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            rdata_reg   <= rdata_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
        end
    end

endmodule
